// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sram_pkg
//  Purpose : Shared constants, read-FSM state encoding and byte-lane helpers
//            for the off-chip SRAM bus responder.
//  Rev     : 1.0  initial release
// ============================================================================
package sram_pkg;

  // Bus geometry of the 16-bit asynchronous SRAM interface
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;

  // Byte-lane layout: lane 0 is DQ[7:0] (LB_N), lane 1 is DQ[15:8] (UB_N)
  localparam int LANE_W  = 8;
  localparam int N_LANES = 2;
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  // Read-side state; writes never occupy a state of their own
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_DRIVE = 2'd2
  } state_t;

  // Convert the active-low byte strobes into an active-high lane mask
  function automatic logic [N_LANES-1:0] lane_en(input logic ub_n, input logic lb_n);
    logic [N_LANES-1:0] en;
    en          = '0;
    en[LANE_HI] = ~ub_n;
    en[LANE_LO] = ~lb_n;
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_byte_array.sv
`default_nettype none
// ============================================================================
//  Module  : sram_byte_array
//  Purpose : 2**DEPTH_LOG2 x 16 word store with a synchronous byte-masked
//            write port and an asynchronous read port.
//  Rev     : 1.0  initial release
// ============================================================================
module sram_byte_array
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16,
  parameter int DATA_W     = SRAM_DATA_W
) (
  input  logic                  clk,
  input  logic [N_LANES-1:0]    be,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  // Contents are deliberately not reset: a real SRAM keeps its data over a
  // core reset, and clearing 64K words would cost a long init sequence.
  logic [DATA_W-1:0] mem_q [0:(2**DEPTH_LOG2)-1];

  // Byte-lane masked write; a zero mask leaves the word untouched
  always_ff @(posedge clk) begin
    for (int l = 0; l < N_LANES; l++) begin
      if (be[l]) begin
        mem_q[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Asynchronous read so the responder can capture the word on the same edge
  // it decides to start driving, and sees a write committed one edge earlier.
  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module  : sram_responder
//  Purpose : Clocked behavioural stand-in for the 16-bit off-chip SRAM. Samples
//            the controller's strobes on every rising edge, commits byte-masked
//            writes immediately and returns read data after READ_LAT edges of
//            a stable read request. DQ is released combinationally the moment
//            the read request goes away.
//  Rev     : 1.0  initial release
// ============================================================================
module sram_responder
  import sram_pkg::*;
#(
  parameter int DATA_W     = SRAM_DATA_W,  // two byte lanes; only 16 is meaningful
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DEPTH_LOG2 = 16,           // implemented words = 2**DEPTH_LOG2
  parameter int READ_LAT   = 2             // legal 1..7
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // Number of additional wait edges spent in RD_WAIT after the first read
  // sample. A request sampled at edge k is driven after edge k+READ_LAT-1, so
  // IDLE->RD_WAIT consumes one edge and the counter covers the rest.
  localparam logic [2:0] c_wait_load = (READ_LAT >= 2) ? 3'(READ_LAT - 2) : 3'd0;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic                  wr_cond;
  logic                  rd_cond;
  logic [N_LANES-1:0]    lane_req;
  logic [DEPTH_LOG2-1:0] idx;
  logic [N_LANES-1:0]    mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  // Decode the strobes; WE_N low wins over OE_N, CE_N high disables both
  always_comb begin
    wr_cond  = ~SRAM_CE_N & ~SRAM_WE_N;
    rd_cond  = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;
    lane_req = lane_en(SRAM_UB_N, SRAM_LB_N);
    idx      = SRAM_ADDR[DEPTH_LOG2-1:0];
    mem_be   = wr_cond ? lane_req : '0;
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  sram_byte_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk   (clk),
    .be    (mem_be),
    .waddr (idx),
    .wdata (SRAM_DQ),
    .raddr (idx),
    .rdata (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,     state_d;
  logic [2:0]          cnt_q,       cnt_d;
  logic                drive_en_q,  drive_en_d;
  logic [ADDR_W-1:0]   lat_addr_q,  lat_addr_d;
  logic [DATA_W-1:0]   dq_q,        dq_d;
  logic [15:0]         rd_count_q,  rd_count_d;
  logic [15:0]         wr_count_q,  wr_count_d;
  logic                w_prev_q,    w_prev_d;
  logic [ADDR_W-1:0]   addr_prev_q, addr_prev_d;
  logic                rd_enter;
  logic                addr_moved;
  logic                wr_start;

  // State register: every flop of the responder; array contents live elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      drive_en_q  <= 1'b0;
      lat_addr_q  <= '0;
      dq_q        <= '0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
      w_prev_q    <= 1'b0;
      addr_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drive_en_q  <= drive_en_d;
      lat_addr_q  <= lat_addr_d;
      dq_q        <= dq_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      w_prev_q    <= w_prev_d;
      addr_prev_q <= addr_prev_d;
    end
  end

  // Next-state logic: read sequencing, address re-latch and wait countdown
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    rd_enter   = 1'b0;
    addr_moved = (SRAM_ADDR != lat_addr_q);

    if (!rd_cond) begin
      // Covers a write (abort), CE_N high and a plain deselect of OE_N
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lat_addr_d = SRAM_ADDR;
          if (READ_LAT == 1) begin
            state_d  = ST_RD_DRIVE;
            rd_enter = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = c_wait_load;
          end
        end
        ST_RD_WAIT: begin
          if (addr_moved) begin
            // Address moved under a pending read: restart the latency window
            lat_addr_d = SRAM_ADDR;
            cnt_d      = c_wait_load;
          end else if (cnt_q == 3'd0) begin
            state_d  = ST_RD_DRIVE;
            rd_enter = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_RD_DRIVE: begin
          if (addr_moved) begin
            lat_addr_d = SRAM_ADDR;
            if (READ_LAT == 1) begin
              // Zero wait edges: the new word is a fresh completed read
              rd_enter = 1'b1;
            end else begin
              state_d = ST_RD_WAIT;
              cnt_d   = c_wait_load;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath logic: drive enable, read capture and access counters
  always_comb begin
    drive_en_d  = (state_d == ST_RD_DRIVE);
    // While driving, keep the captured word tracking the array every edge
    dq_d        = (state_d == ST_RD_DRIVE) ? mem_rdata : dq_q;
    rd_count_d  = rd_count_q + {15'd0, rd_enter};
    // A burst of back-to-back writes to one address counts as one access
    wr_start    = wr_cond & (~w_prev_q | (SRAM_ADDR != addr_prev_q));
    wr_count_d  = wr_count_q + {15'd0, wr_start};
    w_prev_d    = wr_cond;
    addr_prev_d = SRAM_ADDR;
  end

  // --------------------------------------------------------------------------
  // Tristate DQ: gated by the live strobes, not just the registered enable, so
  // the bus is released in the same cycle OE_N rises, WE_N falls or a lane
  // strobe deasserts, without waiting for the next clock edge.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign SRAM_DQ[l*LANE_W +: LANE_W] =
      (drive_en_q && rd_cond && lane_req[l]) ? dq_q[l*LANE_W +: LANE_W] : {LANE_W{1'bz}};
  end

  assign busy     = (state_q != ST_IDLE);
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sram_responder
//  Purpose : Self-checking bench for sram_responder: directed vector table,
//            hand-written multi-cycle sequences and a randomized phase checked
//            against a run-length reference model of the read latency.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sram_responder;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_n, we_n, oe_n, ub_n, lb_n;
  logic [17:0] addr;
  logic [15:0] tb_dq;
  logic        tb_dq_oe;
  wire  [15:0] sram_dq;
  logic        busy;
  logic [15:0] rd_count, wr_count;

  always #5 clk = ~clk;

  // Bench drives DQ only during writes; undriven bits are pulled to 0 so a
  // released lane reads back as 0x00 and a wrongly driven lane shows its data.
  assign sram_dq = tb_dq_oe ? tb_dq : 16'hzzzz;
  for (genvar b = 0; b < 16; b++) begin : g_pd
    pulldown (sram_dq[b]);
  end

  sram_responder #(
    .DATA_W     (16),
    .ADDR_W     (18),
    .DEPTH_LOG2 (16),
    .READ_LAT   (READ_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .busy      (busy),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a read is "stable" for N edges when R held with the same
  // address for N consecutive edges; data is on the bus once N >= READ_LAT.
  // --------------------------------------------------------------------------
  logic [15:0] m_mem [logic [15:0]];
  int          m_stable    = 0;
  logic [17:0] m_run_addr  = '0;
  logic        m_prev_w    = 1'b0;
  logic [17:0] m_prev_addr = '0;
  logic [15:0] m_rd        = '0;
  logic [15:0] m_wr        = '0;

  task automatic model_step();
    logic        wc, rc;
    logic [15:0] cur;
    if (rst) begin
      m_stable = 0; m_rd = '0; m_wr = '0; m_prev_w = 1'b0; m_prev_addr = '0;
      return;
    end
    wc = !ce_n && !we_n;
    rc = !ce_n && we_n && !oe_n;
    if (wc) begin
      if (!m_prev_w || addr != m_prev_addr) m_wr = m_wr + 16'd1;
      cur = m_mem.exists(addr[15:0]) ? m_mem[addr[15:0]] : 16'h0000;
      if (!ub_n) cur[15:8] = tb_dq[15:8];
      if (!lb_n) cur[7:0]  = tb_dq[7:0];
      if (!ub_n || !lb_n) m_mem[addr[15:0]] = cur;
      m_stable = 0;
    end else if (rc) begin
      if (m_stable > 0 && addr == m_run_addr) m_stable++;
      else begin
        m_stable   = 1;
        m_run_addr = addr;
      end
      if (m_stable == READ_LAT) m_rd = m_rd + 16'd1;
    end else begin
      m_stable = 0;
    end
    m_prev_w    = wc;
    m_prev_addr = addr;
  endtask

  function automatic logic [15:0] model_obs();
    logic [15:0] w;
    logic [15:0] r;
    r = 16'h0000;
    if (!ce_n && we_n && !oe_n && m_stable >= READ_LAT && m_mem.exists(m_run_addr[15:0])) begin
      w = m_mem[m_run_addr[15:0]];
      if (!ub_n) r[15:8] = w[15:8];
      if (!lb_n) r[7:0]  = w[7:0];
    end
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, " busy"}, 16'(busy), (m_stable > 0) ? 16'd1 : 16'd0);
    check({tag, " rd_count"}, rd_count, m_rd);
    check({tag, " wr_count"}, wr_count, m_wr);
    if (!tb_dq_oe) check({tag, " dq"}, sram_dq, model_obs());
  endtask

  // Apply one bus cycle, advance the model at the edge, settle 1 time unit
  task automatic cycle(input logic c, input logic w, input logic o, input logic u,
                       input logic l, input logic [17:0] a, input logic [15:0] d);
    ce_n = c; we_n = w; oe_n = o; ub_n = u; lb_n = l; addr = a; tb_dq = d;
    tb_dq_oe = !c && !w;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
  endtask

  // Expect busy / dq / counters after the last cycle
  task automatic expect_st(input string tag, input logic b, input logic [15:0] dq,
                           input logic [15:0] rd, input logic [15:0] wr);
    check({tag, " busy"}, 16'(busy), 16'(b));
    check({tag, " dq"}, sram_dq, dq);
    check({tag, " rd_count"}, rd_count, rd);
    check({tag, " wr_count"}, wr_count, wr);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic        chk_dq;
    logic [15:0] exp_dq;
    logic        exp_busy;
    logic [15:0] exp_rd, exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic w, input logic o, input logic u,
                              input logic l, input logic [17:0] a, input logic [15:0] d,
                              input logic chk, input logic [15:0] edq, input logic eb,
                              input logic [15:0] erd, input logic [15:0] ewr);
    vec_t v;
    v.ce_n = c; v.we_n = w; v.oe_n = o; v.ub_n = u; v.lb_n = l;
    v.addr = a; v.wdata = d; v.chk_dq = chk; v.exp_dq = edq;
    v.exp_busy = eb; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    int          op;
    logic [17:0] a;
    logic [17:0] cur_a;

    // ---------------- table contents ----------------
    //            ce we oe ub lb addr      data      chk dq       busy rd wr
    tbl[0]  = mk(0, 0, 1, 0, 0, 18'h00010, 16'h1234, 0, 16'h0000, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 0, 0, 18'h00010, 16'h0000, 1, 16'h0000, 1, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0, 0, 18'h00010, 16'h0000, 1, 16'h1234, 1, 1, 1);
    tbl[3]  = mk(1, 1, 1, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 0, 1, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 18'h00005, 16'hABCD, 0, 16'h0000, 0, 1, 2);
    tbl[5]  = mk(0, 0, 1, 1, 0, 18'h00005, 16'h00EF, 0, 16'h0000, 0, 1, 2);
    tbl[6]  = mk(0, 1, 0, 0, 0, 18'h00005, 16'h0000, 1, 16'h0000, 1, 1, 2);
    tbl[7]  = mk(0, 1, 0, 0, 0, 18'h00005, 16'h0000, 1, 16'hABEF, 1, 2, 2);
    tbl[8]  = mk(0, 1, 0, 0, 1, 18'h00005, 16'h0000, 1, 16'hAB00, 1, 2, 2);
    tbl[9]  = mk(1, 1, 1, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 0, 2, 2);
    tbl[10] = mk(0, 0, 1, 0, 0, 18'h10000, 16'h5A5A, 0, 16'h0000, 0, 2, 3);
    tbl[11] = mk(1, 1, 1, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 0, 2, 3);
    tbl[12] = mk(0, 1, 0, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 1, 2, 3);
    tbl[13] = mk(0, 1, 0, 0, 0, 18'h00000, 16'h0000, 1, 16'h5A5A, 1, 3, 3);
    tbl[14] = mk(1, 1, 1, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 0, 3, 3);
    tbl[15] = mk(0, 0, 1, 1, 1, 18'h00000, 16'hFFFF, 0, 16'h0000, 0, 3, 4);
    tbl[16] = mk(0, 1, 0, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 1, 3, 4);
    tbl[17] = mk(0, 1, 0, 0, 0, 18'h00000, 16'h0000, 1, 16'h5A5A, 1, 4, 4);
    tbl[18] = mk(1, 1, 1, 0, 0, 18'h00000, 16'h0000, 1, 16'h0000, 0, 4, 4);

    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;
    expect_st("init", 1'b0, 16'h0000, 16'd0, 16'd0);

    // ---------------- reset held mid-read ----------------
    cycle(0, 0, 1, 0, 0, 18'h8, 16'h8888);
    cycle(0, 1, 0, 0, 0, 18'h8, 16'h0);
    cycle(0, 1, 0, 0, 0, 18'h8, 16'h0);
    expect_st("pre_rst", 1'b1, 16'h8888, 16'd1, 16'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0, 18'h8, 16'h0);
      expect_st($sformatf("rst%0d", i), 1'b0, 16'h0000, 16'd0, 16'd0);
    end
    rst = 1'b0;
    cycle(0, 1, 0, 0, 0, 18'h8, 16'h0);
    expect_st("post_rst wait", 1'b1, 16'h0000, 16'd0, 16'd0);
    cycle(0, 1, 0, 0, 0, 18'h8, 16'h0);
    expect_st("post_rst keep", 1'b1, 16'h8888, 16'd1, 16'd0);

    // ---------------- vector table ----------------
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].ce_n, tbl[i].we_n, tbl[i].oe_n, tbl[i].ub_n, tbl[i].lb_n,
            tbl[i].addr, tbl[i].wdata);
      check($sformatf("vec%0d busy", i), 16'(busy), 16'(tbl[i].exp_busy));
      check($sformatf("vec%0d rd_count", i), rd_count, tbl[i].exp_rd);
      check($sformatf("vec%0d wr_count", i), wr_count, tbl[i].exp_wr);
      if (tbl[i].chk_dq) check($sformatf("vec%0d dq", i), sram_dq, tbl[i].exp_dq);
    end

    // ---------------- address change while driving ----------------
    do_reset();
    cycle(0, 0, 1, 0, 0, 18'h3, 16'h1111);
    cycle(0, 0, 1, 0, 0, 18'h4, 16'h2222);
    cycle(0, 1, 0, 0, 0, 18'h3, 16'h0);
    expect_st("move wait3", 1'b1, 16'h0000, 16'd0, 16'd2);
    cycle(0, 1, 0, 0, 0, 18'h3, 16'h0);
    expect_st("move drv3", 1'b1, 16'h1111, 16'd1, 16'd2);
    cycle(0, 1, 0, 0, 0, 18'h4, 16'h0);
    expect_st("move gap", 1'b1, 16'h0000, 16'd1, 16'd2);
    cycle(0, 1, 0, 0, 0, 18'h4, 16'h0);
    expect_st("move drv4", 1'b1, 16'h2222, 16'd2, 16'd2);

    // ---------------- OE_N release and write abort ----------------
    do_reset();
    cycle(0, 0, 1, 0, 0, 18'h6, 16'h6666);
    cycle(0, 1, 0, 0, 0, 18'h6, 16'h0);
    cycle(0, 1, 0, 0, 0, 18'h6, 16'h0);
    expect_st("oe drv", 1'b1, 16'h6666, 16'd1, 16'd1);
    oe_n = 1'b1;
    #1;
    check("oe same-cycle release dq", sram_dq, 16'h0000);
    check("oe same-cycle busy", 16'(busy), 16'd1);
    cycle(0, 1, 1, 0, 0, 18'h6, 16'h0);
    expect_st("oe idle", 1'b0, 16'h0000, 16'd1, 16'd1);
    cycle(0, 1, 0, 0, 0, 18'h6, 16'h0);
    check("abort wait busy", 16'(busy), 16'd1);
    cycle(0, 0, 0, 0, 0, 18'h6, 16'h7777);
    check("abort busy", 16'(busy), 16'd0);
    check("abort wr_count", wr_count, 16'd2);
    check("abort rd_count", rd_count, 16'd1);
    idle();
    cycle(0, 1, 0, 0, 0, 18'h6, 16'h0);
    cycle(0, 1, 0, 0, 0, 18'h6, 16'h0);
    expect_st("abort readback", 1'b1, 16'h7777, 16'd2, 16'd2);

    // ---------------- randomized phase against the model ----------------
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 18'(i), 16'($urandom));
    check_model("prefill");
    cur_a = 18'h0;
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 99));
      a  = 18'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[16] = 1'b1;
      if (op < 45) begin
        cycle(0, 1, 0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), cur_a, 16'h0);
      end else if (op < 58) begin
        cur_a = a;
        cycle(0, 1, 0, 0, 0, cur_a, 16'h0);
      end else if (op < 76) begin
        if ($urandom_range(0, 1) == 0) a = cur_a;
        cycle(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), a, 16'($urandom));
      end else if (op < 88) begin
        cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, a, 16'h0);
      end else begin
        cycle(0, 1, 1, 0, 0, cur_a, 16'h0);
      end
      check_model($sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the run is a fixed number of cycles, so this only fires on a hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
